operand_fetch: RTL and testbench

- Decode-to-execute stage that sits directly upstream of the 16-bit ALU.
- Holds the 16-entry x 16-bit register file and one pipeline register.
- Produces the ALU operands `a` and `b` and the ALU select `s` under a valid/ready handshake.
- Accepts writeback from downstream and bypasses it into operands being read or held.

---
 rtl/operand_fetch.sv | 161 ++++++++++++++++
 tb/tb_operand_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute stage feeding the 16-bit ALU.
//
// Holds the architectural register file and a single pipeline register that
// presents ALU operands a/b and select s under a valid/ready handshake.
// Writeback from downstream updates the register file at the rising edge.
//
// Optional feature (macro OPERAND_FETCH_BYPASS_EN):
//   defined   - writeback is forwarded into operands being captured this cycle,
//               and into held operands that were sourced from the written register.
//   undefined - captures read pre-write contents and held operands never change.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid, in_ready          upstream handshake
//   rs1, rs2, imm, use_imm      operand sources (imm replaces rs2 when use_imm=1)
//   alu_sel                     ALU opcode, passed through to s
//   out_valid, out_ready        downstream handshake
//   a, b, s                     registered ALU operands and select
//   wb_en, wb_addr, wb_data     register writeback port
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    // Derived from NREGS; not meant to be overridden.
    parameter int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [3:0]        alu_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [3:0]        s,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] rf_q [NREGS];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        s_q, s_d;

    logic              capture;
    logic              wb_live;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

`ifdef OPERAND_FETCH_BYPASS_EN
    // Source tracking for the held operation so later writes can be snooped.
    logic [ADDR_W-1:0] a_src_q, a_src_d;
    logic [ADDR_W-1:0] b_src_q, b_src_d;
    logic              b_is_reg_q, b_is_reg_d;
`endif

    // Handshake: depends only on state and out_ready, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready;
    // Writes to register 0 are discarded, so they never forward either.
    assign wb_live  = wb_en && (wb_addr != '0);

    // Register file read ports; register 0 is hardwired to zero.
    always_comb begin
        rd_a = (rs1 == '0) ? '0 : rf_q[rs1];
        rd_b = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_live && (wb_addr == rs1)) begin
            rd_a = wb_data;
        end
        if (wb_live && (wb_addr == rs2)) begin
            rd_b = wb_data;
        end
`endif
    end

    // Pipeline register next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
`ifdef OPERAND_FETCH_BYPASS_EN
        a_src_d     = a_src_q;
        b_src_d     = b_src_q;
        b_is_reg_d  = b_is_reg_q;
`endif
        if (capture) begin
            out_valid_d = 1'b1;
            a_d         = rd_a;
            b_d         = use_imm ? imm : rd_b;
            s_d         = alu_sel;
`ifdef OPERAND_FETCH_BYPASS_EN
            a_src_d     = rs1;
            b_src_d     = rs2;
            b_is_reg_d  = !use_imm;
`endif
        end else if (in_ready) begin
            // Consumed (or idle) with nothing new: bubble; operands are don't-care.
            out_valid_d = 1'b0;
        end else begin
            // Stalled: hold, except for snooped writeback when bypass is enabled.
`ifdef OPERAND_FETCH_BYPASS_EN
            if (wb_live && (wb_addr == a_src_q)) begin
                a_d = wb_data;
            end
            if (wb_live && b_is_reg_q && (wb_addr == b_src_q)) begin
                b_d = wb_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
            a_src_q     <= '0;
            b_src_q     <= '0;
            b_is_reg_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
`ifdef OPERAND_FETCH_BYPASS_EN
            a_src_q     <= a_src_d;
            b_src_q     <= b_src_d;
            b_is_reg_q  <= b_is_reg_d;
`endif
        end
    end

    // Register file storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign s         = s_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// traffic, with a scoreboard queue filled at capture and drained by a monitor.
module tb_operand_fetch;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic [DW-1:0] imm = '0;
    logic          use_imm = 1'b0;
    logic [3:0]    alu_sel = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    s;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .use_imm   (use_imm),
        .alu_sel   (alu_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    s;
        int            a_src;
        int            b_src;
        bit            b_is_reg;
    } op_t;

    op_t     sb[$];
    int      regs[16];
    int      checks = 0;
    int      errors = 0;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented operation with the oldest expectation.
    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() == 0) || out_ready});
        if (sb.size() == 0) begin
            chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
        end else begin
            chk("out_valid_busy", {31'd0, out_valid}, 32'd1);
            chk("a", {16'd0, a}, {16'd0, sb[0].a});
            chk("b", {16'd0, b}, {16'd0, sb[0].b});
            chk("s", {28'd0, s}, {28'd0, sb[0].s});
            if (out_valid && out_ready) begin
                void'(sb.pop_front());
            end
        end
    end

    // Reference read: register 0 is zero; same-cycle forwarding only with bypass.
    function automatic logic [DW-1:0] ref_read(input int r, input bit we, input int wa,
                                              input logic [DW-1:0] wd);
        if (r == 0) return '0;
        if (BYPASS && we && wa == r) return wd;
        return regs[r][DW-1:0];
    endfunction

    // One clock of stimulus; the model is advanced after the monitor has run.
    task automatic step(input bit iv, input int r1, input int r2, input logic [DW-1:0] im,
                        input bit ui, input logic [3:0] sel, input bit ordy,
                        input bit we, input int wa, input logic [DW-1:0] wd);
        op_t op;
        @(posedge clk);
        #1;
        in_valid  = iv;
        rs1       = AW'(r1);
        rs2       = AW'(r2);
        imm       = im;
        use_imm   = ui;
        alu_sel   = sel;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = AW'(wa);
        wb_data   = wd;
        @(negedge clk);
        #1;
        // After the monitor, a non-empty queue means the head is stalled.
        if (sb.size() != 0) begin
            if (BYPASS && we && wa != 0) begin
                if (sb[0].a_src == wa) sb[0].a = wd;
                if (sb[0].b_is_reg && sb[0].b_src == wa) sb[0].b = wd;
            end
        end else if (iv) begin
            op.a        = ref_read(r1, we, wa, wd);
            op.b        = ui ? im : ref_read(r2, we, wa, wd);
            op.s        = sel;
            op.a_src    = r1;
            op.b_src    = r2;
            op.b_is_reg = !ui;
            sb.push_back(op);
        end
        if (we && wa != 0) regs[wa] = int'(wd);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 0, '0, 1'b0, 4'd0, ordy, 1'b0, 0, '0);
    endtask

    task automatic wr(input int wa, input logic [DW-1:0] wd);
        step(1'b0, 0, 0, '0, 1'b0, 4'd0, 1'b1, 1'b1, wa, wd);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", {16'd0, a}, 32'd0);
        chk("rst_b", {16'd0, b}, 32'd0);
        chk("rst_s", {28'd0, s}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic register-register issue.
        wr(3, 16'h1234);
        wr(5, 16'h0F0F);
        step(1'b1, 3, 5, '0, 1'b0, 4'b0010, 1'b1, 1'b0, 0, '0);
        idle(1'b1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_a", {16'd0, a}, 32'h1234);
        chk("t1_b", {16'd0, b}, 32'h0F0F);
        chk("t1_s", {28'd0, s}, 32'h2);

        // Register 0 ignores writes; immediate operand.
        wr(0, 16'hFFFF);
        step(1'b1, 0, 0, 16'h8001, 1'b1, 4'b0101, 1'b1, 1'b0, 0, '0);
        idle(1'b1);
        chk("t2_a", {16'd0, a}, 32'h0000);
        chk("t2_b", {16'd0, b}, 32'h8001);

        // Back-to-back issue into a stalled consumer.
        step(1'b1, 3, 5, '0, 1'b0, 4'b0001, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5, 0, 16'h00C3, 1'b1, 4'b0111, 1'b0, 1'b0, 0, '0);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_a", {16'd0, a}, 32'h1234);
            chk("stall_s", {28'd0, s}, 32'h1);
        end
        step(1'b1, 5, 0, 16'h00C3, 1'b1, 4'b0111, 1'b1, 1'b0, 0, '0);
        idle(1'b1);
        chk("stall_b_a", {16'd0, a}, 32'h0F0F);
        chk("stall_b_b", {16'd0, b}, 32'h00C3);
        idle(1'b1);
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Write to the register being read in the same cycle.
        wr(7, 16'h1111);
        step(1'b1, 7, 0, '0, 1'b0, 4'b0011, 1'b1, 1'b1, 7, 16'hBEEF);
        idle(1'b1);
        chk("same_cycle_a", {16'd0, a}, BYPASS ? 32'hBEEF : 32'h1111);

        // Write to the source of a held operand, register and immediate forms.
        wr(2, 16'h0001);
        step(1'b1, 3, 2, '0, 1'b0, 4'b0100, 1'b0, 1'b0, 0, '0);
        step(1'b0, 0, 0, '0, 1'b0, 4'd0, 1'b0, 1'b1, 2, 16'h00AA);
        idle(1'b0);
        chk("snoop_b", {16'd0, b}, BYPASS ? 32'h00AA : 32'h0001);
        idle(1'b1);
        step(1'b1, 3, 2, 16'h0002, 1'b1, 4'b0100, 1'b0, 1'b0, 0, '0);
        step(1'b0, 0, 0, '0, 1'b0, 4'd0, 1'b0, 1'b1, 2, 16'h5555);
        idle(1'b0);
        chk("snoop_imm_b", {16'd0, b}, 32'h0002);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while stalled.
        step(1'b1, 3, 5, '0, 1'b0, 4'b1001, 1'b0, 1'b0, 0, '0);
        idle(1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_a", {16'd0, a}, 32'd0);
        chk("mid_rst_b", {16'd0, b}, 32'd0);
        chk("mid_rst_s", {28'd0, s}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        for (int i = 0; i < 16; i++) regs[i] = 0;
        #1 rst = 1'b0;
        step(1'b1, 3, 5, '0, 1'b0, 4'b0010, 1'b1, 1'b0, 0, '0);
        idle(1'b1);
        chk("post_rst_r3", {16'd0, a}, 32'd0);
        chk("post_rst_r5", {16'd0, b}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 3) == 0,
                 4'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), DW'($urandom));
        end

        repeat (4) idle(1'b1);
        chk("final_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound in case the stimulus ever stops advancing.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
